// File: rtl/fsm_pulse_pkg.sv
// -----------------------------------------------------------------------------
// fsm_pulse_pkg
// Shared definitions for the pulse emitter:
//   - pulse_state_t : 2-bit FSM state encoding (IDLE, PULSE, GAP, DONE)
//   - CNT_W_DEF, GAP_CYCLES_DEF : default parameter values
//   - gap_timer_w() : gap timer width, $clog2(GAP_CYCLES+1) with a floor of 1
// -----------------------------------------------------------------------------
package fsm_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } pulse_state_t;

    localparam int CNT_W_DEF      = 2;
    localparam int GAP_CYCLES_DEF = 1;

    function automatic int gap_timer_w(input int gap);
        return (gap < 1) ? 1 : $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/fsm_gap_timer.sv
// -----------------------------------------------------------------------------
// fsm_gap_timer
// Loadable down-counter that times the low gap between pulses.
// Ports:
//   clk   in  clock
//   reset in  synchronous, active-high; clears the count
//   load  in  load the count with GAP_CYCLES (has priority over en)
//   en    in  decrement by one (saturates at 0)
//   zero  out the decrement taking place this cycle brings the count to 0,
//             so the owning FSM can leave the gap on this same edge
// -----------------------------------------------------------------------------
module fsm_gap_timer
    import fsm_pulse_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int             TW       = gap_timer_w(GAP_CYCLES);
    localparam logic [TW-1:0]  LOAD_VAL = TW'(GAP_CYCLES);
    localparam logic [TW-1:0]  ONE      = TW'(1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of 1 means the current decrement is the last one.
    assign zero = (cnt_q <= ONE);

endmodule

// File: rtl/fsm_pulse_emitter.sv
// -----------------------------------------------------------------------------
// fsm_pulse_emitter
// Accepts a pulse count over valid/ready and emits that many one-cycle pulses
// on dout, separated by GAP_CYCLES low cycles, then strobes done for one cycle.
// All outputs are registered decodes of the FSM state.
// Optional feature macro: FSM_PULSE_MIRROR_EN adds tx_mod, a modulo-2^CNT_W
// count of emitted pulses that tracks a downstream pulse counter.
// Ports:
//   clk        in  clock
//   reset      in  synchronous, active-high; aborts any request without done
//   req_valid  in  request presented
//   req_ready  out block is idle and can accept a request
//   req_count  in  number of pulses (CNT_W bits), sampled on handshake
//   dout       out pulse stream
//   busy       out request in progress (PULSE or GAP)
//   done       out one-cycle completion strobe
//   tx_mod     out pulses emitted modulo 2^CNT_W (FSM_PULSE_MIRROR_EN only)
// -----------------------------------------------------------------------------
module fsm_pulse_emitter
    import fsm_pulse_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_count,
    output logic             dout,
    output logic             busy,
    output logic             done
`ifdef FSM_PULSE_MIRROR_EN
    ,
    output logic [CNT_W-1:0] tx_mod
`endif
);

    pulse_state_t     state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] remain_dec;
    logic             req_ready_q, dout_q, busy_q, done_q;
    logic             gap_load, gap_en, gap_zero;

    // remain is always >= 1 while in PULSE, so this never wraps in use.
    assign remain_dec = remain_q - CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        gap_load = 1'b0;
        gap_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    remain_d = req_count;
                    state_d  = (req_count == '0) ? DONE : PULSE;
                end
            end
            PULSE: begin
                remain_d = remain_dec;
                if (remain_dec == '0) begin
                    state_d = DONE;
                end else if (GAP_CYCLES == 0) begin
                    state_d = PULSE;
                end else begin
                    gap_load = 1'b1;
                    state_d  = GAP;
                end
            end
            GAP: begin
                gap_en = 1'b1;
                if (gap_zero) begin
                    state_d = PULSE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they always equal a
    // decode of the current state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remain_q    <= '0;
            req_ready_q <= 1'b1;
            dout_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            req_ready_q <= (state_d == IDLE);
            dout_q      <= (state_d == PULSE);
            busy_q      <= (state_d == PULSE) || (state_d == GAP);
            done_q      <= (state_d == DONE);
        end
    end

    assign req_ready = req_ready_q;
    assign dout      = dout_q;
    assign busy      = busy_q;
    assign done      = done_q;

    generate
        if (GAP_CYCLES > 0) begin : g_gap
            fsm_gap_timer #(
                .GAP_CYCLES (GAP_CYCLES)
            ) u_gap_timer (
                .clk   (clk),
                .reset (reset),
                .load  (gap_load),
                .en    (gap_en),
                .zero  (gap_zero)
            );
        end else begin : g_no_gap
            // GAP is never entered when pulses run back to back.
            logic unused_gap_ctrl;
            assign unused_gap_ctrl = gap_load ^ gap_en;
            assign gap_zero        = 1'b1;
        end
    endgenerate

`ifdef FSM_PULSE_MIRROR_EN
    logic [CNT_W-1:0] tx_mod_q, tx_mod_d;

    // Advances on each cycle dout is high, wrapping like the receiving counter.
    always_comb begin
        tx_mod_d = tx_mod_q + CNT_W'(dout_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_mod_q <= '0;
        end else begin
            tx_mod_q <= tx_mod_d;
        end
    end

    assign tx_mod = tx_mod_q;
`endif

endmodule

// File: tb/tb_fsm_pulse_emitter.sv
// -----------------------------------------------------------------------------
// tb_fsm_pulse_emitter
// Two instances: A with GAP_CYCLES=1, B with GAP_CYCLES=0, both CNT_W=2.
// Stimulus pushes the expected pulse and done cycle numbers into queues; the
// monitors pop and compare whenever dout or done is seen. Cycle c is the
// period that follows the c-th rising edge (cyc counts edges).
// FSM_PULSE_MIRROR_EN, when defined, also connects and checks tx_mod on A.
// -----------------------------------------------------------------------------
module tb_fsm_pulse_emitter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset_a, valid_a, ready_a, dout_a, busy_a, done_a;
    logic [1:0] count_a;
    logic       reset_b, valid_b, ready_b, dout_b, busy_b, done_b;
    logic [1:0] count_b;
`ifdef FSM_PULSE_MIRROR_EN
    logic [1:0] tx_a, tx_b;
`endif

    fsm_pulse_emitter #(.CNT_W(2), .GAP_CYCLES(1)) u_dut_a (
        .clk       (clk),
        .reset     (reset_a),
        .req_valid (valid_a),
        .req_ready (ready_a),
        .req_count (count_a),
        .dout      (dout_a),
        .busy      (busy_a),
        .done      (done_a)
`ifdef FSM_PULSE_MIRROR_EN
        ,
        .tx_mod    (tx_a)
`endif
    );

    fsm_pulse_emitter #(.CNT_W(2), .GAP_CYCLES(0)) u_dut_b (
        .clk       (clk),
        .reset     (reset_b),
        .req_valid (valid_b),
        .req_ready (ready_b),
        .req_count (count_b),
        .dout      (dout_b),
        .busy      (busy_b),
        .done      (done_b)
`ifdef FSM_PULSE_MIRROR_EN
        ,
        .tx_mod    (tx_b)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    int exp_pulse_a[$];
    int exp_done_a[$];
    int exp_pulse_b[$];
    int exp_done_b[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected pulse cycles h+1+i*(g+1) and done cycle h+1+(n-1)*(g+1)+1
    // (h+1 for n=0). only_first keeps just the first pulse for an aborted request.
    function automatic void push_exp(input bit sel_b, input int h, input int n,
                                     input int g, input bit only_first);
        for (int i = 0; i < n; i++) begin
            if (!(only_first && i > 0)) begin
                if (sel_b) exp_pulse_b.push_back(h + 1 + i * (g + 1));
                else       exp_pulse_a.push_back(h + 1 + i * (g + 1));
            end
        end
        if (!only_first) begin
            int d;
            d = (n == 0) ? h + 1 : h + 1 + (n - 1) * (g + 1) + 1;
            if (sel_b) exp_done_b.push_back(d);
            else       exp_done_a.push_back(d);
        end
    endfunction

    // Monitors
    always @(negedge clk) begin
        if (dout_a) begin
            if (exp_pulse_a.size() == 0) chk("a_unexpected_pulse", cyc, -1);
            else                         chk("a_pulse_cycle", cyc, exp_pulse_a.pop_front());
        end
        if (done_a) begin
            if (exp_done_a.size() == 0) chk("a_unexpected_done", cyc, -1);
            else                        chk("a_done_cycle", cyc, exp_done_a.pop_front());
        end
    end

    always @(negedge clk) begin
        if (dout_b) begin
            if (exp_pulse_b.size() == 0) chk("b_unexpected_pulse", cyc, -1);
            else                         chk("b_pulse_cycle", cyc, exp_pulse_b.pop_front());
        end
        if (done_b) begin
            if (exp_done_b.size() == 0) chk("b_unexpected_done", cyc, -1);
            else                        chk("b_done_cycle", cyc, exp_done_b.pop_front());
        end
    end

    // Presents a request, waits (bounded) for the handshake, records its cycle.
    // Called and returns #1 after a rising edge.
    task automatic issue(input bit sel_b, input int n, input bit only_first,
                         input bit keep_valid, output int h);
        h = -1;
        if (sel_b) begin count_b = 2'(n); valid_b = 1'b1; end
        else       begin count_a = 2'(n); valid_a = 1'b1; end
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if ((sel_b ? ready_b : ready_a) == 1'b1) begin
                h = cyc;
                break;
            end
        end
        if (h < 0) chk(sel_b ? "b_handshake_timeout" : "a_handshake_timeout", 0, 1);
        else       push_exp(sel_b, h, n, sel_b ? 0 : 1, only_first);
        @(posedge clk);
        #1;
        if (!keep_valid) begin
            if (sel_b) valid_b = 1'b0;
            else       valid_a = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (exp_pulse_a.size() == 0 && exp_done_a.size() == 0 &&
                exp_pulse_b.size() == 0 && exp_done_b.size() == 0 &&
                ready_a && ready_b) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, h2;
        reset_a = 1'b1; valid_a = 1'b0; count_a = 2'd0;
        reset_b = 1'b1; valid_b = 1'b0; count_b = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Reset state
        @(negedge clk);
        chk("a_rst_ready", ready_a, 1);
        chk("a_rst_dout",  dout_a,  0);
        chk("a_rst_busy",  busy_a,  0);
        chk("a_rst_done",  done_a,  0);
        chk("b_rst_ready", ready_b, 1);
        chk("b_rst_dout",  dout_b,  0);
        chk("b_rst_busy",  busy_b,  0);
        chk("b_rst_done",  done_b,  0);
`ifdef FSM_PULSE_MIRROR_EN
        chk("a_rst_tx", int'(tx_a), 0);
        chk("b_rst_tx", int'(tx_b), 0);
`endif
        @(posedge clk);
        #1;

        // count=3, G=1: pulses h+1,h+3,h+5, done h+6, ready h+7
        issue(1'b0, 3, 1'b0, 1'b0, h);
        wait_cyc(h + 2);
        chk("a3_gap_busy", busy_a, 1);
        chk("a3_gap_dout", dout_a, 0);
        chk("a3_gap_ready", ready_a, 0);
        wait_cyc(h + 6);
        chk("a3_done_busy", busy_a, 0);
        chk("a3_done_ready", ready_a, 0);
        wait_cyc(h + 7);
        chk("a3_ready_back", ready_a, 1);
        chk("a3_idle_done", done_a, 0);
        drain();

        // count=0: done at h+1, ready at h+2, busy never
        issue(1'b0, 0, 1'b0, 1'b0, h);
        wait_cyc(h + 1);
        chk("a0_done", done_a, 1);
        chk("a0_busy_d", busy_a, 0);
        chk("a0_ready_d", ready_a, 0);
        wait_cyc(h + 2);
        chk("a0_ready", ready_a, 1);
        chk("a0_busy", busy_a, 0);
        drain();

        // count=2, G=1
        issue(1'b0, 2, 1'b0, 1'b0, h);
        drain();

        // G=0, count=2, valid held: re-accepted 4 cycles later; the count
        // changed mid-request must not affect the request in flight.
        issue(1'b1, 2, 1'b0, 1'b1, h);
        count_b = 2'd1;
        wait_cyc(h + 2);
        chk("b2_busy_run", busy_b, 1);
        h2 = -1;
        for (int t = 0; t < 20; t++) begin
            if (ready_b) begin
                h2 = cyc;
                break;
            end
            @(negedge clk);
        end
        if (h2 < 0) chk("b_reaccept_timeout", 0, 1);
        else begin
            chk("b_reaccept_interval", h2 - h, 4);
            push_exp(1'b1, h2, 1, 0, 1'b0);
        end
        @(posedge clk);
        #1;
        valid_b = 1'b0;
        drain();

        // G=0, count=3: one run of three high cycles
        issue(1'b1, 3, 1'b0, 1'b0, h);
        drain();

        // Reset during the gap (cycle h+2) of a count=3 request
        issue(1'b0, 3, 1'b1, 1'b0, h);
        @(posedge clk);
        #1;
        reset_a = 1'b1;
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        @(negedge clk);
        chk("arst_ready", ready_a, 1);
        chk("arst_dout",  dout_a,  0);
        chk("arst_busy",  busy_a,  0);
        chk("arst_done",  done_a,  0);
`ifdef FSM_PULSE_MIRROR_EN
        chk("arst_tx", int'(tx_a), 0);
`endif
        repeat (8) @(negedge clk);
        chk("arst_still_idle", ready_a, 1);
        @(posedge clk);
        #1;

`ifdef FSM_PULSE_MIRROR_EN
        issue(1'b0, 3, 1'b0, 1'b0, h);
        drain();
        chk("mirror_after_3", int'(tx_a), 3);
        issue(1'b0, 2, 1'b0, 1'b0, h);
        drain();
        chk("mirror_after_2", int'(tx_a), 1);
        issue(1'b0, 3, 1'b0, 1'b0, h);
        drain();
        chk("mirror_after_3b", int'(tx_a), 0);
`endif

        // Recovery after the aborted request
        issue(1'b0, 1, 1'b0, 1'b0, h);
        drain();

        chk("a_pulse_q_empty", exp_pulse_a.size(), 0);
        chk("a_done_q_empty",  exp_done_a.size(),  0);
        chk("b_pulse_q_empty", exp_pulse_b.size(), 0);
        chk("b_done_q_empty",  exp_done_b.size(),  0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fsm_pulse_emitter.md
# fsm_pulse_emitter

Transmit-side companion to the team's din pulse counter. It accepts a count over a valid/ready handshake and emits that many single-cycle high pulses on `dout`, spaced by a fixed gap, so a downstream modulo-2^CNT_W pulse counter advances by exactly the requested amount. It signals completion with a one-cycle `done` strobe. It sits between a control/sequencer block and any din-driven counter FSM.

## Interface
- `CNT_W`, default 2: width of the requested count and of the mirror counter.
- `GAP_CYCLES`, default 1: number of low cycles inserted between consecutive pulses. Legal range is 0..255; 0 gives back-to-back pulses.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  a request is presented.
- `req_ready`  out  1  the block can accept a request.
- `req_count`  in  CNT_W  number of pulses to emit; sampled on handshake.
- `dout`  out  1  pulse stream to the counter's din.
- `busy`  out  1  a request is in progress (PULSE or GAP state).
- `done`  out  1  one-cycle completion strobe.
- `tx_mod`  out  CNT_W  count of pulses emitted, modulo 2^CNT_W. Present only with `FSM_PULSE_MIRROR_EN`.

## Operation
- The FSM has four states: IDLE, PULSE, GAP, DONE.
- All outputs are Moore outputs, decoded from registered state only. There is no combinational input-to-output path.
  - `req_ready` = (state==IDLE).
  - `dout` = (state==PULSE).
  - `busy` = (state==PULSE or GAP).
  - `done` = (state==DONE).
- **IDLE:** on `req_valid && req_ready`, latch `req_count` into `remain`.
  - `req_count==0` → go to DONE. No pulse is emitted.
  - Otherwise → go to PULSE.
- **PULSE:** decrement `remain`.
  - If the new `remain==0` → go to DONE.
  - Else if `GAP_CYCLES==0` → stay in PULSE.
  - Else → load the gap timer with `GAP_CYCLES` and go to GAP.
- **GAP:** decrement the gap timer. When it reaches 0 → go to PULSE.
- **DONE:** → go to IDLE unconditionally.
- `req_valid`, `req_count` and `req_valid` deassertion are ignored outside IDLE. A request is never queued.
- Width rules:
  - `remain` is CNT_W bits, so the maximum count is 2^CNT_W−1 (3 by default). `remain` never wraps.
  - The gap timer is $clog2(GAP_CYCLES+1) bits, with a minimum of 1.
- **Reset, including mid-request:**
  - state → IDLE and `remain` → 0. The in-flight request is discarded without a `done`.
  - The gap timer → 0 and `tx_mod` → 0.
  - Output values in reset: `req_ready`=1, `dout`=0, `busy`=0, `done`=0.
- Reset has priority over a handshake in the same cycle.

## Timing
- Handshake at edge k, count N≥1, gap G:
  - Pulse i (i=0..N−1) is high in cycle k+1+i·(G+1).
  - `done` is high in cycle k+1+(N−1)(G+1)+1.
  - `req_ready` returns high in the cycle after `done`.
- Handshake at edge k with N=0: `done` is high in cycle k+1 and `req_ready` is high in cycle k+2.
- The minimum request-to-request interval is N·(G+1)−G+2 cycles for N≥1, and 2 cycles for N=0.
- Each pulse is exactly one cycle wide. With G=0, N pulses form one contiguous high run of N cycles.

## Configuration
- `FSM_PULSE_MIRROR_EN` defined:
  - Adds the `tx_mod` port and its register.
  - `tx_mod` increments on every cycle with `dout`=1 and wraps from 2^CNT_W−1 to 0.
  - The intent is that it matches the value of a receiving counter that has the same reset.
- `FSM_PULSE_MIRROR_EN` undefined: no port and no register. All other behaviour is identical.

## Structure
- Shared package `fsm_pulse_pkg` contains:
  - typedef `pulse_state_t`, a 2-bit enum: IDLE=2'b00, PULSE=2'b01, GAP=2'b10, DONE=2'b11.
  - The default constants for CNT_W and GAP_CYCLES.
- One sub-module, `fsm_gap_timer`:
  - Loadable down-counter parameterised by GAP_CYCLES.
  - Inputs: `load`, `en`. Output: `zero`.
  - Instantiated only when GAP_CYCLES>0.

## Test plan
- Reset held 3 cycles, then released → `req_ready`=1, `dout`=0, `busy`=0, `done`=0 (`tx_mod`=0 with mirror).
- count=3, G=1, handshake at edge 0 → `dout` high in cycles 1, 3, 5; `done` in cycle 6; `req_ready` in cycle 7.
- count=0 → no `dout` pulse; `done` in cycle 1; `busy` never asserted.
- G=0, count=2 → `dout` high in cycles 1–2 contiguously; `done` in cycle 3. `req_valid` held high throughout is accepted again only in cycle 4.
- Reset asserted in cycle 2 of a count=3, G=1 request → from the next cycle: IDLE, `dout`=0, no `done`, `tx_mod`=0.
- Mirror build: requests 3, then 2, then 3 → `tx_mod` reads 3, then 1, then 0 after each `done`.
